// File: rtl/mem_copy_initiator.sv
// Word-wide bus master that copies COUNT aligned words from src to dst and
// keeps a modular checksum of every word it read during the last transfer.
module mem_copy_initiator #(
  parameter int WIDTH   = 32,
  parameter int CNTBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   src,
  input  logic [WIDTH-1:0]   dst,
  input  logic [CNTBITS-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   checksum,
  output logic               memread,
  output logic               memwrite,
  output logic [WIDTH-1:0]   adr,
  output logic [WIDTH-1:0]   writedata,
  input  logic [WIDTH-1:0]   memdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]   WORD_STEP = WIDTH'(3'd4);
  localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};
  localparam logic [CNTBITS-1:0] CNT_ZERO  = {CNTBITS{1'b0}};
  localparam logic [CNTBITS-1:0] CNT_ONE   = CNTBITS'(1'b1);

  state_t               state_q,     state_d;
  logic [WIDTH-1:0]     src_ptr_q,   src_ptr_d;
  logic [WIDTH-1:0]     dst_ptr_q,   dst_ptr_d;
  logic [CNTBITS-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]     data_q,      data_d;
  logic [WIDTH-1:0]     checksum_q,  checksum_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic                 err_q,       err_d;
  logic                 memread_q,   memread_d;
  logic                 memwrite_q,  memwrite_d;
  logic [WIDTH-1:0]     adr_q,       adr_d;
  logic [WIDTH-1:0]     writedata_q, writedata_d;
  logic                 misaligned_s;

  assign misaligned_s = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);

  // Next-state, pointer, counter and checksum logic.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (misaligned_s) begin
            state_d = S_ERR;
          end else if (count == CNT_ZERO) begin
            state_d    = S_DONE;
            checksum_d = ZERO_W;
          end else begin
            state_d    = S_READ;
            src_ptr_d  = src;
            dst_ptr_d  = dst;
            cnt_d      = count;
            checksum_d = ZERO_W;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        data_d     = memdata;
        checksum_d = checksum_q + memdata;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        src_ptr_d = src_ptr_q + WORD_STEP;
        dst_ptr_d = dst_ptr_q + WORD_STEP;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs are precomputed from the next state so they leave flops.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    adr_d       = ZERO_W;
    writedata_d = ZERO_W;
    case (state_d)
      S_READ: begin
        busy_d    = 1'b1;
        memread_d = 1'b1;
        adr_d     = src_ptr_d;
      end
      S_WRITE: begin
        busy_d      = 1'b1;
        memwrite_d  = 1'b1;
        adr_d       = dst_ptr_d;
        writedata_d = data_d;
      end
      S_DONE:  done_d = 1'b1;
      S_ERR:   err_d  = 1'b1;
      S_IDLE:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts a transfer without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= ZERO_W;
      dst_ptr_q   <= ZERO_W;
      cnt_q       <= CNT_ZERO;
      data_q      <= ZERO_W;
      checksum_q  <= ZERO_W;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      adr_q       <= ZERO_W;
      writedata_q <= ZERO_W;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      adr_q       <= adr_d;
      writedata_q <= writedata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign adr       = adr_q;
  assign writedata = writedata_q;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed plus randomized bench for mem_copy_initiator with a zero-wait memory
// and a word-array reference model of forward copy and checksum.
module tb_mem_copy_initiator;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;
  logic        memread;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] memdata;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int tests;
  int fails;
  logic [31:0] last_sum;

  mem_copy_initiator #(.WIDTH(32), .CNTBITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst),
    .count(count), .busy(busy), .done(done), .err(err),
    .checksum(checksum), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memdata = mem[adr[11:2]];

  always @(posedge clk) begin
    if (memwrite) mem[adr[11:2]] = writedata;
  end

  function automatic int idx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Runs one copy from the IDLE negedge; glitch_c re-pulses start, rst_c aborts via reset.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int glitch_c, input int rst_c);
    logic [31:0] sum;
    logic [31:0] rd;
    int k;
    bit aborted;
    sum = 32'd0;
    rd = 32'd0;
    aborted = 1'b0;
    start = 1'b1; src = s; dst = d; count = 8'(n);
    @(posedge clk);
    for (int c = 1; c <= 2*n + 1; c++) begin
      @(negedge clk);
      if (c == glitch_c) begin
        start = 1'b1; src = s + 32'h40; dst = d + 32'h80; count = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (c == rst_c) begin
        reset = 1'b0;
        #1;
        chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      k = (c - 1) / 2;
      if (c == 2*n + 1) begin
        chk("done", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_bus", {30'd0, memread, memwrite}, 32'd0);
        chk("done_adr", adr, 32'd0);
      end else if (c % 2 == 1) begin
        rd = ref_mem[idx(s + 32'(4*k))];
        sum = sum + rd;
        chk("rd_strobes", {29'd0, busy, memread, memwrite}, 32'h6);
        chk("rd_adr", adr, s + 32'(4*k));
        chk("rd_done", {31'd0, done}, 32'd0);
      end else begin
        ref_mem[idx(d + 32'(4*k))] = rd;
        chk("wr_strobes", {29'd0, busy, memread, memwrite}, 32'h5);
        chk("wr_adr", adr, d + 32'(4*k));
        chk("wr_data", writedata, rd);
      end
    end
    if (!aborted) begin
      chk("checksum", checksum, sum);
      last_sum = sum;
      @(negedge clk);
      chk("idle_after_done", {29'd0, done, busy, err}, 32'd0);
    end
    chk_mem("mem_image");
  endtask

  // Issues a start that must be rejected and verifies the err pulse and held checksum.
  task automatic run_err(input logic [31:0] s, input logic [31:0] d, input int n);
    start = 1'b1; src = s; dst = d; count = 8'(n);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_quiet", {29'd0, busy, memread, memwrite}, 32'd0);
    chk("err_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("err_one_cycle", {31'd0, err}, 32'd0);
    chk("err_checksum_held", checksum, last_sum);
    chk_mem("err_mem_image");
  endtask

  initial begin
    logic [31:0] rs;
    logic [31:0] rd;
    int rn;
    tests = 0; fails = 0; last_sum = 32'd0;
    reset = 1'b0; start = 1'b0; src = 32'd0; dst = 32'd0; count = 8'd0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'd1; mem[1] = 32'd1; mem[2] = 32'd2;
    ref_mem[0] = 32'd1; ref_mem[1] = 32'd1; ref_mem[2] = 32'd2;
    repeat (2) @(negedge clk);
    chk("reset_flags", {27'd0, busy, done, err, memread, memwrite}, 32'd0);
    chk("reset_adr", adr, 32'd0);
    chk("reset_wdata", writedata, 32'd0);
    chk("reset_checksum", checksum, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_copy(32'h0, 32'h100, 3, 0, 0);
    chk("fib_checksum", checksum, 32'd4);
    chk("fib_word2", mem[66], 32'd2);

    run_err(32'h2, 32'h0, 5);
    run_err(32'h0, 32'h101, 1);

    run_copy(32'h0, 32'h0, 0, 0, 0);
    chk("zero_count_checksum", checksum, 32'd0);

    run_copy(32'h20, 32'h300, 4, 3, 0);

    mem[10] = 32'hFFFF_FFFF; mem[11] = 32'h0000_0002;
    ref_mem[10] = 32'hFFFF_FFFF; ref_mem[11] = 32'h0000_0002;
    run_copy(32'h28, 32'h200, 2, 0, 0);
    chk("wrap_checksum", checksum, 32'h0000_0001);

    run_copy(32'hFFFF_FFFC, 32'h400, 2, 0, 0);

    run_copy(32'h40, 32'h44, 6, 0, 0);

    for (int t = 0; t < 6; t++) begin
      rs = 32'($urandom_range(0, 200)) << 2;
      rd = 32'($urandom_range(0, 200)) << 2;
      rn = int'($urandom_range(1, 20));
      run_copy(rs, rd, rn, 0, 0);
    end

    run_copy(32'h80, 32'h500, 5, 0, 6);
    @(negedge clk);
    run_copy(32'h80, 32'h600, 5, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_copy_initiator.md
Name: mem_copy_initiator

Overview:
- Bus-master counterpart to the external memory model: drives memread/memwrite/adr/writedata and consumes memdata on the same word-wide interface the MIPS core uses.
- Copies COUNT 32-bit words from a source byte address to a destination byte address and accumulates a modular checksum of the copied data.
- Used in the testbench to preload or relocate program/data images and to move results (e.g. the fib word at byte 252) for checking. Can later sit behind a bus arbiter as a DMA engine.

Parameters:
- WIDTH, 32, data/address width in bits; addresses are byte addresses, word index = adr>>2.
- CNTBITS, 8, width of the word-count input; maximum transfer is 2^CNTBITS-1 words.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- src  input  WIDTH  source byte address; sampled with start.
- dst  input  WIDTH  destination byte address; sampled with start.
- count  input  CNTBITS  number of words; sampled with start.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle pulse on completion.
- err  output  1  one-cycle pulse on a rejected start.
- checksum  output  WIDTH  sum of all words read in the last transfer, mod 2^WIDTH; holds its value until the next accepted start.
- memread  output  1  read strobe.
- memwrite  output  1  write strobe; the memory commits on the rising edge while high.
- adr  output  WIDTH  byte address.
- writedata  output  WIDTH  write data.
- memdata  input  WIDTH  read data; combinationally valid in the same cycle adr is presented (zero-wait memory).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all pointers, counter, data register and checksum are cleared.
  - busy, done, err, memread and memwrite are 0; adr=0, writedata=0.
  - Takes effect immediately mid-transfer. Words already written stay in memory. No done pulse is generated.
- Bus outputs are decoded from registered state and registers only. There is no combinational path from start/src/dst/count to the bus.
- States:
  - IDLE: bus idle.
    - start=1 with src[1:0]!=0 or dst[1:0]!=0 -> ERR.
    - start=1 with count=0 -> DONE (checksum cleared to 0).
    - start=1 otherwise -> READ. Latch src/dst/count; clear checksum.
  - READ: memread=1, adr=src pointer, memwrite=0.
    - At the edge: data register <= memdata; checksum <= checksum + memdata; -> WRITE.
  - WRITE: memwrite=1, adr=dst pointer, writedata=data register, memread=0.
    - At the edge: src and dst pointers +4 (wrap mod 2^WIDTH); remaining count -1.
    - -> DONE if the remaining count was 1, else -> READ.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - ERR: err=1 for exactly one cycle; no bus activity; checksum unchanged -> IDLE.
- Timing: start sampled at edge 0. First memread is in cycle 1. Word k is written at the end of cycle 2k+2. done is high in cycle 2N+1, so start-to-done latency is 2N+1 cycles. For count=0, done is high in cycle 1.
- start while busy, DONE or ERR is ignored: no queuing, no error.
- Overlapping regions use forward-copy semantics: each word is read immediately before its own write. If dst=src+4, word 0 propagates through the whole range; this is defined and required.
- In IDLE/DONE/ERR, adr and writedata are 0. memread and memwrite are never high together.

Test Plan:
- Memory words 0..2 = 1,1,2; start src=0, dst=0x100, count=3 -> memwrite at adr 256,260,264 with data 1,1,2 in cycles 2,4,6; done high in cycle 7; checksum=4; busy high in cycles 1-6.
- count=0, src=0, dst=0 -> no memread/memwrite; done high in cycle 1; checksum=0.
- start with src=2 (misaligned), count=5 -> err high for 1 cycle; no bus strobes; prior checksum retained; busy stays 0.
- During a 4-word copy, pulse start again in cycle 3 with different src -> ignored; the original 4 writes complete unchanged.
- Source words 0xFFFFFFFF, 0x00000002 copied -> checksum=0x00000001 (wrap). Separately, src=0xFFFFFFFC with count=2 -> second read at adr=0 (pointer wrap).
- Assert reset low mid-WRITE of word 2 of 5 -> memwrite drops immediately; words 0-1 remain in memory; no done. After release, a new start runs a full copy normally.
